matmul_ctrl: RTL and testbench
==============================

Name: matmul_ctrl

Overview:
- Sequencer for the matrix-multiply datapath behind the APB slave.
- Accepts a start command from the register file and drives the datapath through a fixed sequence: clear the accumulators, stream operand rows in, flush the systolic array, write the result rows to a scratchpad target.
- Owns the mulbusy indication that the APB slave uses to block bus access while a multiply is in progress.

Parameters:
- DATA_WIDTH, 8, operand element width.
- BUS_WIDTH, 32, bus and row-vector width.
- SP_NTARGETS, 4, number of scratchpad result targets.
- DIM, BUS_WIDTH/DATA_WIDTH, maximum matrix dimension (derived; do not override).

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle start pulse from the control register write.
- dim_i  in  clog2(DIM)  runtime dimension minus 1 (n = dim_i+1); latched at start.
- sp_tgt_i  in  clog2(SP_NTARGETS)  result target; latched at start.
- busy_o  out  1  multiply in progress; feeds mulbusy_i of the APB slave.
- pe_clr_o  out  1  clear the PE accumulators.
- op_rd_en_o  out  1  operand row read request (read data is valid 1 cycle later).
- op_idx_o  out  clog2(DIM)  operand row index.
- pe_shift_o  out  1  advance the systolic array by one step.
- zero_inj_o  out  1  datapath injects zeros instead of operand data.
- res_wr_en_o  out  1  result row write strobe.
- res_idx_o  out  clog2(DIM)  result row index.
- sp_sel_o  out  clog2(SP_NTARGETS)  latched result target.
- done_o  out  1  one-cycle completion pulse.
- ovl_err_o  out  1  one-cycle pulse when start_i arrives while busy.
- perf_cnt_o  out  16  busy-cycle count (see Optional Feature).

Behaviour:
- All outputs are registered (Moore). Reset value of every output is 0; the FSM resets to IDLE. Reset applies asynchronously, including mid-operation.
- States: IDLE, CLEAR, FEED, FLUSH, WRITE, DONE. One internal counter, cnt, is zeroed on each state entry.
- IDLE:
  - start_i=1 latches n and sp_tgt_i, then moves to CLEAR.
  - busy_o=0.
- CLEAR:
  - 1 cycle, pe_clr_o=1.
  - Moves to FEED.
- FEED:
  - n+1 cycles.
  - Cycles 0..n-1: op_rd_en_o=1, op_idx_o=cnt.
  - Cycles 1..n: pe_shift_o=1, matching the 1-cycle read latency.
  - Moves to FLUSH; if n=1 (FLUSH length 0), moves directly to WRITE.
- FLUSH:
  - 2n-2 cycles, pe_shift_o=1, zero_inj_o=1.
- WRITE:
  - n cycles, res_wr_en_o=1, res_idx_o=cnt, sp_sel_o=latched target.
- DONE:
  - 1 cycle, done_o=1.
  - Moves to IDLE.
- busy_o=1 in every state except IDLE: it rises the cycle after the accepted start_i and falls the cycle after done_o.
- Total start-to-done latency is 4n+1 cycles; done_o is registered in cycle 4n+1 after the start cycle. For n=4 this is 17 cycles.
- start_i while busy_o=1:
  - The command is ignored; the latched n and target are unchanged.
  - ovl_err_o=1 in the following cycle.
- start_i in the DONE cycle counts as busy and is rejected.
- op_idx_o and res_idx_o hold 0 outside their strobe cycles. sp_sel_o holds its latched value until the next accepted start.
- dim_i and sp_tgt_i changing during an operation have no effect.

Optional Feature:
- Macro MATMUL_CTRL_PERF_EN.
- Defined:
  - perf_cnt_o clears to 0 on an accepted start and increments every cycle busy_o=1.
  - Saturates at 16'hFFFF.
  - Holds its value in IDLE; resets to 0.
- Undefined: perf_cnt_o is tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset: assert rst_i mid-FEED for n=4 -> all outputs go to 0 immediately, FSM in IDLE; a subsequent start_i runs a full 17-cycle sequence.
- Full size: dim_i=3, sp_tgt_i=2, start_i pulse ->
  - pe_clr_o 1 cycle;
  - op_rd_en_o 4 cycles with idx 0,1,2,3;
  - pe_shift_o 10 consecutive cycles, zero_inj_o on the last 6;
  - res_wr_en_o 4 cycles with idx 0..3 and sp_sel_o=2;
  - done_o at start+17.
- Minimum size: dim_i=0 -> no FLUSH cycles, pe_shift_o 1 cycle, res_wr_en_o 1 cycle with idx 0, done_o at start+5.
- Overlap: start_i at start+3 and at start+17 (the DONE cycle) -> ovl_err_o pulses at +4 and +18; latched n and target unchanged; busy_o falls at +18.
- Back-to-back: start_i one cycle after busy_o falls -> accepted; second done_o arrives 4n+1 cycles later.
- PERF (MATMUL_CTRL_PERF_EN defined): one n=4 run -> perf_cnt_o=17 in IDLE; a second n=2 run -> perf_cnt_o=9. Without the macro -> perf_cnt_o stays 0 throughout.

Source files
------------

// File: rtl/matmul_ctrl.sv
// Matrix-multiply sequencer: clear, feed operand rows, flush, write results.
// Ports: clk_i/rst_i, start_i/dim_i/sp_tgt_i command in; busy_o, PE controls,
//   operand read and result write strobes, done_o, ovl_err_o, perf_cnt_o.
// Optional: define MATMUL_CTRL_PERF_EN to enable the busy-cycle counter.
module matmul_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUS_WIDTH   = 32,
  parameter int SP_NTARGETS = 4,
  parameter int DIM         = BUS_WIDTH / DATA_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [$clog2(DIM)-1:0]         dim_i,
  input  logic [$clog2(SP_NTARGETS)-1:0] sp_tgt_i,
  output logic                           busy_o,
  output logic                           pe_clr_o,
  output logic                           op_rd_en_o,
  output logic [$clog2(DIM)-1:0]         op_idx_o,
  output logic                           pe_shift_o,
  output logic                           zero_inj_o,
  output logic                           res_wr_en_o,
  output logic [$clog2(DIM)-1:0]         res_idx_o,
  output logic [$clog2(SP_NTARGETS)-1:0] sp_sel_o,
  output logic                           done_o,
  output logic                           ovl_err_o,
  output logic [15:0]                    perf_cnt_o
);

  localparam int IW = $clog2(DIM);
  localparam int CW = $clog2(2 * DIM) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] n_q;
  logic          accept;

  logic          busy_d;
  logic          clr_d;
  logic          rd_d;
  logic [IW-1:0] op_idx_d;
  logic          shift_d;
  logic          zero_d;
  logic          wr_d;
  logic [IW-1:0] res_idx_d;
  logic          done_d;
  logic          ovl_d;

  assign accept = (state_q == S_IDLE) && start_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start_i) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        // n reads plus one trailing shift for the read latency
        if (cnt_q == n_q) begin
          cnt_d   = '0;
          state_d = (n_q == CW'(1)) ? S_WRITE : S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (cnt_q == (n_q << 1) - CW'(3)) begin
          cnt_d   = '0;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_q == n_q - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // outputs decoded from the next state so they register in step with it
    busy_d    = (state_d != S_IDLE);
    clr_d     = (state_d == S_CLEAR);
    rd_d      = (state_d == S_FEED) && (cnt_d < n_q);
    op_idx_d  = rd_d ? IW'(cnt_d) : '0;
    shift_d   = ((state_d == S_FEED) && (cnt_d != '0))
              || (state_d == S_FLUSH);
    zero_d    = (state_d == S_FLUSH);
    wr_d      = (state_d == S_WRITE);
    res_idx_d = wr_d ? IW'(cnt_d) : '0;
    done_d    = (state_d == S_DONE);
    ovl_d     = start_i && (state_q != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      sp_sel_o    <= '0;
      busy_o      <= 1'b0;
      pe_clr_o    <= 1'b0;
      op_rd_en_o  <= 1'b0;
      op_idx_o    <= '0;
      pe_shift_o  <= 1'b0;
      zero_inj_o  <= 1'b0;
      res_wr_en_o <= 1'b0;
      res_idx_o   <= '0;
      done_o      <= 1'b0;
      ovl_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        n_q      <= CW'(dim_i) + CW'(1);
        sp_sel_o <= sp_tgt_i;
      end
      busy_o      <= busy_d;
      pe_clr_o    <= clr_d;
      op_rd_en_o  <= rd_d;
      op_idx_o    <= op_idx_d;
      pe_shift_o  <= shift_d;
      zero_inj_o  <= zero_d;
      res_wr_en_o <= wr_d;
      res_idx_o   <= res_idx_d;
      done_o      <= done_d;
      ovl_err_o   <= ovl_d;
    end
  end

`ifdef MATMUL_CTRL_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy_o && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Testbench for matmul_ctrl: per-cycle expected output records are queued
// when a command is driven and popped against the DUT each cycle.
module tb_matmul_ctrl;

`ifdef MATMUL_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  dim;
  logic [1:0]  tgt;
  logic        busy;
  logic        clr;
  logic        rd;
  logic [1:0]  op_idx;
  logic        shift;
  logic        zero;
  logic        wr;
  logic [1:0]  res_idx;
  logic [1:0]  sel;
  logic        done;
  logic        ovl;
  logic [15:0] perf;

  typedef struct packed {
    logic       busy;
    logic       clr;
    logic       rd;
    logic [1:0] idx;
    logic       shift;
    logic       zero;
    logic       wr;
    logic [1:0] ridx;
    logic [1:0] sel;
    logic       done;
    logic       ovl;
  } exp_t;

  exp_t q[$];
  exp_t ex;
  exp_t act;
  int   errors = 0;
  int   checks = 0;

  matmul_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .dim_i      (dim),
    .sp_tgt_i   (tgt),
    .busy_o     (busy),
    .pe_clr_o   (clr),
    .op_rd_en_o (rd),
    .op_idx_o   (op_idx),
    .pe_shift_o (shift),
    .zero_inj_o (zero),
    .res_wr_en_o(wr),
    .res_idx_o  (res_idx),
    .sp_sel_o   (sel),
    .done_o     (done),
    .ovl_err_o  (ovl),
    .perf_cnt_o (perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t pack_out();
    exp_t a;
    a = '{busy, clr, rd, op_idx, shift, zero, wr, res_idx, sel, done, ovl};
    return a;
  endfunction

  // Expected trace for cycles 1..4n+1 after an accepted start.
  task automatic push_run(input int n, input logic [1:0] t);
    exp_t e;
    int   j;
    for (int k = 1; k <= 4 * n + 1; k++) begin
      e      = '0;
      e.busy = 1'b1;
      e.sel  = t;
      if (k == 1) begin
        e.clr = 1'b1;
      end else if (k <= n + 2) begin
        j = k - 2;
        if (j < n) begin
          e.rd  = 1'b1;
          e.idx = 2'(j);
        end
        if (j >= 1) e.shift = 1'b1;
      end else if (k <= 3 * n) begin
        e.shift = 1'b1;
        e.zero  = 1'b1;
      end else if (k <= 4 * n) begin
        e.wr   = 1'b1;
        e.ridx = 2'(k - 3 * n - 1);
      end else begin
        e.done = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  task automatic push_idle(input logic [1:0] t, input int cnt);
    exp_t e;
    for (int k = 0; k < cnt; k++) begin
      e     = '0;
      e.sel = t;
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (pack_out() !== exp_t'(0) || perf !== 16'd0) begin
      errors++;
      $display("FAIL reset_init got %h/%h exp 0/0", pack_out(), perf);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    dim   = 2'd3;
    tgt   = 2'd1;
    push_run(4, 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      ex  = q.pop_front();
      act = pack_out();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL reset_pre cyc%0d got %h exp %h", k, act, ex);
      end
    end
    q.delete();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pack_out() !== exp_t'(0) || perf !== 16'd0) begin
      errors++;
      $display("FAIL reset_async got %h/%h exp 0/0", pack_out(), perf);
    end
    @(negedge clk);
    checks++;
    if (pack_out() !== exp_t'(0)) begin
      errors++;
      $display("FAIL reset_hold got %h exp 0", pack_out());
    end
    rst   = 1'b0;
    start = 1'b1;
    dim   = 2'd3;
    tgt   = 2'd3;
    push_run(4, 3);
    push_idle(3, 1);
    for (int k = 1; q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      ex  = q.pop_front();
      act = pack_out();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL reset_rerun cyc%0d got %h exp %h", k, act, ex);
      end
    end
  endtask

  task automatic test_full();
    @(negedge clk);
    start = 1'b1;
    dim   = 2'd3;
    tgt   = 2'd2;
    push_run(4, 2);
    push_idle(2, 2);
    for (int k = 1; q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      dim   = 2'($urandom_range(0, 3));
      tgt   = 2'($urandom_range(0, 3));
      ex  = q.pop_front();
      act = pack_out();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL full cyc%0d got %h exp %h", k, act, ex);
      end
    end
  endtask

  task automatic test_min();
    @(negedge clk);
    start = 1'b1;
    dim   = 2'd0;
    tgt   = 2'd1;
    push_run(1, 1);
    push_idle(1, 2);
    for (int k = 1; q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      ex  = q.pop_front();
      act = pack_out();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL min cyc%0d got %h exp %h", k, act, ex);
      end
    end
  endtask

  task automatic test_overlap();
    @(negedge clk);
    start = 1'b1;
    dim   = 2'd3;
    tgt   = 2'd2;
    push_run(4, 2);
    push_idle(2, 2);
    q[3].ovl  = 1'b1;
    q[17].ovl = 1'b1;
    for (int k = 1; q.size() > 0; k++) begin
      @(negedge clk);
      ex  = q.pop_front();
      act = pack_out();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL overlap cyc%0d got %h exp %h", k, act, ex);
      end
      start = (k == 3) || (k == 17);
      dim   = 2'd0;
      tgt   = 2'd0;
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1;
    dim   = 2'd1;
    tgt   = 2'd3;
    push_run(2, 3);
    push_idle(3, 1);
    push_run(3, 0);
    push_idle(0, 2);
    for (int k = 1; q.size() > 0; k++) begin
      @(negedge clk);
      ex  = q.pop_front();
      act = pack_out();
      checks++;
      if (act !== ex) begin
        errors++;
        $display("FAIL b2b cyc%0d got %h exp %h", k, act, ex);
      end
      start = (k == 10);
      dim   = 2'd2;
      tgt   = 2'd0;
    end
    start = 1'b0;
  endtask

  task automatic test_perf(input int n);
    logic [15:0] ep;
    @(negedge clk);
    start = 1'b1;
    dim   = 2'(n - 1);
    tgt   = 2'd1;
    push_run(n, 1);
    push_idle(1, 2);
    for (int k = 1; q.size() > 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      ex  = q.pop_front();
      act = pack_out();
      ep  = PERF_ON ? 16'((k <= 4 * n + 2) ? k - 1 : 4 * n + 1) : 16'd0;
      checks++;
      if (act !== ex || perf !== ep) begin
        errors++;
        $display("FAIL perf n%0d cyc%0d got %h/%0d exp %h/%0d",
                 n, k, act, perf, ex, ep);
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    dim   = 2'd0;
    tgt   = 2'd0;
    test_reset();
    test_full();
    test_min();
    test_overlap();
    test_back_to_back();
    test_perf(4);
    test_perf(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
